// File: rtl/multi_blinker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_blinker_pkg : mode encodings and tick/width helpers for multi_blinker
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
package multi_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  localparam int C_TICK_HZ = 1000;

  // Clock cycles per 1 ms tick; the clock frequency is a multiple of 1 kHz.
  function automatic int tick_cycles(input int clk_frq);
    return clk_frq / C_TICK_HZ;
  endfunction

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ms_tick_gen : free-running prescaler emitting a one-cycle tick every 1 ms
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module ms_tick_gen
  import multi_blinker_pkg::*;
#(
  parameter int C_CLK_FRQ = 100_000_000
) (
  input  logic clk,
  input  logic rstb,
  output logic tick
);

  localparam int C_TICK_CYCLES = tick_cycles(C_CLK_FRQ);
  localparam int C_CW          = min1_clog2(C_TICK_CYCLES);
  localparam logic [C_CW-1:0] C_MAX = C_CW'(C_TICK_CYCLES - 1);

  logic [C_CW-1:0] count;

  assign tick = (count == C_MAX);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_blinker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_blinker : N-channel OFF/ON/BLINK/BURST indicator pattern generator
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module multi_blinker
  import multi_blinker_pkg::*;
#(
  parameter int C_CLK_FRQ  = 100_000_000,
  parameter int C_CHANNELS = 4,
  parameter int C_PW       = 10,
  parameter int C_BW       = 4,
  localparam int C_CHW     = min1_clog2(C_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [C_CHW-1:0]      cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [C_PW-1:0]       cfg_period,
  input  logic [C_PW-1:0]       cfg_high,
  input  logic [C_BW-1:0]       cfg_burst,
  output logic                  cfg_err,
  output logic [C_CHANNELS-1:0] out,
  output logic [C_CHANNELS-1:0] done
);

  logic tick;
  logic accept;
  logic ch_ok;

  ms_tick_gen #(
    .C_CLK_FRQ(C_CLK_FRQ)
  ) u_tick (
    .clk (clk),
    .rstb(rstb),
    .tick(tick)
  );

  assign accept = cfg_valid & cfg_ready;
  assign ch_ok  = (32'(cfg_ch) < C_CHANNELS);

  // Dropping ready after each accept gives the channel one apply cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= ~accept;
      cfg_err   <= accept & ~ch_ok;
    end
  end

  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
    mode_e           mode;
    logic [C_PW-1:0] period;
    logic [C_PW-1:0] high;
    logic [C_PW-1:0] ms_cnt;
    logic [C_BW-1:0] burst_rem;
    logic            zero_pend;
    logic            out_q;
    logic            done_q;
    logic            sel;
    logic            wrap;
    logic            blink_on;
    logic            out_nxt;
    logic            burst_end;

    assign sel      = accept & ch_ok & (cfg_ch == C_CHW'(i));
    assign wrap     = (period != '0) && (ms_cnt == period - 1'b1);
    assign blink_on = (period != '0) && (ms_cnt < high);
    assign out_nxt  = (mode == MODE_ON)    ? 1'b1 :
                      (mode == MODE_BLINK) ? blink_on :
                      (mode == MODE_BURST) ? (blink_on && (burst_rem != '0)) :
                                             1'b0;
    assign burst_end = tick && wrap && (mode == MODE_BURST) && (burst_rem == C_BW'(1));

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        mode      <= MODE_OFF;
        period    <= '0;
        high      <= '0;
        ms_cnt    <= '0;
        burst_rem <= '0;
        zero_pend <= 1'b0;
        out_q     <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        out_q  <= out_nxt;
        done_q <= zero_pend | (~sel & burst_end);
        if (sel) begin
          // A write restarts the phase; any coincident tick is ignored.
          mode      <= mode_e'(cfg_mode);
          period    <= cfg_period;
          high      <= cfg_high;
          ms_cnt    <= '0;
          burst_rem <= cfg_burst;
          zero_pend <= (mode_e'(cfg_mode) == MODE_BURST) && (cfg_burst == '0);
        end else begin
          zero_pend <= 1'b0;
          if (tick) begin
            if (period == '0 || wrap) begin
              ms_cnt <= '0;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
            if (wrap && mode == MODE_BURST && burst_rem != '0) begin
              burst_rem <= burst_rem - 1'b1;
            end
          end
        end
      end
    end

    assign out[i]  = out_q;
    assign done[i] = done_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_blinker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multi_blinker : randomized bench for multi_blinker against a ms-count model
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multi_blinker;

  // Five channels so the 3-bit channel index can also address invalid channels.
  localparam int NCH = 5;
  localparam int PW  = 10;
  localparam int BW  = 4;
  localparam int CPM = 10;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [2:0]     cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic [PW-1:0]  cfg_high = '0;
  logic [BW-1:0]  cfg_burst = '0;
  logic           cfg_err;
  logic [NCH-1:0] out;
  logic [NCH-1:0] done;

  multi_blinker #(
    .C_CLK_FRQ (CPM * 1000),
    .C_CHANNELS(NCH),
    .C_PW      (PW),
    .C_BW      (BW)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_burst (cfg_burst),
    .cfg_err   (cfg_err),
    .out       (out),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each channel remembers its config and the number of ms ticks since its last write.
  int m_mode [NCH];
  int m_per  [NCH];
  int m_high [NCH];
  int m_burst[NCH];
  int m_k    [NCH];
  bit m_zp   [NCH];
  bit m_ready;
  int e;
  bit last_acc;

  function automatic void model_reset();
    for (int j = 0; j < NCH; j++) begin
      m_mode[j] = 0; m_per[j] = 0; m_high[j] = 0; m_burst[j] = 0; m_k[j] = 0; m_zp[j] = 0;
    end
    m_ready = 0;
    e = 0;
  endfunction

  function automatic bit exp_out(input int j);
    int ph, np;
    bit bl;
    ph = (m_per[j] > 0) ? m_k[j] % m_per[j] : 0;
    np = (m_per[j] > 0) ? m_k[j] / m_per[j] : 0;
    bl = (m_per[j] > 0) && (ph < m_high[j]);
    case (m_mode[j])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return bl;
      default: return bl && (np < m_burst[j]);
    endcase
  endfunction

  // One clock edge: predict from the pre-edge model, advance it, then compare.
  task automatic step();
    bit tick, acc, wr;
    logic [NCH-1:0] eo, ed;
    bit eerr;
    @(posedge clk);
    #1;
    e++;
    tick = (e % CPM == 0);
    acc  = cfg_valid && m_ready;
    wr   = acc && (int'(cfg_ch) < NCH);
    for (int j = 0; j < NCH; j++) begin
      eo[j] = exp_out(j);
      ed[j] = m_zp[j] ||
              (!(wr && int'(cfg_ch) == j) && m_mode[j] == 3 && m_per[j] > 0 &&
               m_burst[j] > 0 && tick && (m_k[j] + 1 == m_burst[j] * m_per[j]));
    end
    for (int j = 0; j < NCH; j++) begin
      if (wr && int'(cfg_ch) == j) begin
        m_mode[j]  = int'(cfg_mode);
        m_per[j]   = int'(cfg_period);
        m_high[j]  = int'(cfg_high);
        m_burst[j] = int'(cfg_burst);
        m_k[j]     = 0;
        m_zp[j]    = (cfg_mode == 2'd3) && (cfg_burst == '0);
      end else begin
        m_zp[j] = 0;
        if (tick) m_k[j]++;
      end
    end
    eerr     = acc && !wr;
    m_ready  = !acc;
    last_acc = acc;
    check("out", 32'(out), 32'(eo));
    check("done", 32'(done), 32'(ed));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check("cfg_err", 32'(cfg_err), 32'(eerr));
  endtask

  task automatic write(input int ch, input int mode, input int per, input int hi, input int bur);
    bit got;
    cfg_valid  = 1'b1;
    cfg_ch     = 3'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = PW'(per);
    cfg_high   = PW'(hi);
    cfg_burst  = BW'(bur);
    got = 0;
    for (int n = 0; n < 4 && !got; n++) begin
      step();
      got = last_acc;
    end
    cfg_valid = 1'b0;
    check("write_accepted", 32'(got), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pulses, dones, accs;
    logic prev;
    model_reset();

    // Reset and release off the clock edge.
    #23;
    check("reset_out", 32'(out), 32'd0);
    check("reset_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #2;
    rstb = 1'b1;
    run(3);

    // ch0 BLINK period 4 high 1.
    write(0, 2, 4, 1, 0);
    run(120);

    // ch2 BURST period 2 high 1 burst 3: three pulses then a single done.
    write(2, 3, 2, 1, 3);
    pulses = 0; dones = 0; prev = out[2];
    for (int i = 0; i < 100; i++) begin
      step();
      if (out[2] && !prev) pulses++;
      if (done[2]) dones++;
      prev = out[2];
    end
    check("burst_pulses", 32'(pulses), 32'd3);
    check("burst_dones", 32'(dones), 32'd1);
    check("burst_idle", 32'(out[2]), 32'd0);

    // Back-to-back writes: valid held across the apply cycle.
    accs = 0;
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'd1;
    cfg_period = '0; cfg_high = '0; cfg_burst = '0;
    step(); accs += int'(last_acc);
    cfg_ch = 3'd3; cfg_mode = 2'd2; cfg_period = PW'(3); cfg_high = PW'(2);
    step(); accs += int'(last_acc);
    step(); accs += int'(last_acc);
    cfg_valid = 1'b0;
    check("b2b_accepts", 32'(accs), 32'd2);
    run(40);

    // Invalid channel.
    write(5, 1, 3, 1, 2);
    run(5);

    // Write ch1 on the same edge as a tick.
    for (int n = 0; n < 30 && !(((e + 1) % CPM == 0) && m_ready); n++) step();
    write(1, 2, 3, 1, 0);
    check("tick_aligned_write", 32'(e % CPM), 32'd0);
    run(60);

    // Edge cases.
    write(3, 2, 3, 3, 0);
    write(4, 2, 0, 5, 0);
    write(0, 3, 4, 2, 0);
    run(50);
    check("high_eq_period", 32'(out[3]), 32'd1);
    check("period_zero", 32'(out[4]), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!cfg_valid || ($urandom_range(0, 3) == 0)) begin
        cfg_valid  = ($urandom_range(0, 7) == 0);
        cfg_ch     = 3'($urandom_range(0, 7));
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_period = PW'($urandom_range(0, 6));
        cfg_high   = PW'($urandom_range(0, 7));
        cfg_burst  = BW'($urandom_range(0, 4));
      end
      step();
    end
    cfg_valid = 1'b0;

    // Reset mid-run, asynchronous to the clock.
    write(0, 2, 4, 2, 0);
    run(15);
    #3;
    rstb = 1'b0;
    #1;
    check("async_reset_out", 32'(out), 32'd0);
    check("async_reset_ready", 32'(cfg_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    check("held_reset_ready", 32'(cfg_ready), 32'd0);
    rstb = 1'b1;
    model_reset();
    run(5);
    write(2, 2, 2, 1, 0);
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
